// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the IMEM byte-stream loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEN0,
      ST_LEN1,
      ST_DATA,
      ST_CSUM,
      ST_RUN,
      ST_ERR
   } loader_state_t;

   typedef enum logic [1:0] {
      ERR_NONE = 2'd0,
      ERR_LEN  = 2'd1,
      ERR_CSUM = 2'd2
   } err_code_t;

   localparam logic [7:0] SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/imem_loader_if.sv
// Valid/ready byte stream feeding the loader; master is the byte source.
interface imem_loader_if;
   logic       byte_valid;
   logic [7:0] byte_data;
   logic       byte_ready;

   modport master (output byte_valid, output byte_data, input  byte_ready);
   modport slave  (input  byte_valid, input  byte_data, output byte_ready);
endinterface

// File: rtl/imem_loader.sv
// Framed byte-stream loader: assembles LE words into IMEM writes, holds the
// core in reset until the XOR checksum of the data bytes matches.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W    = 8,
   parameter int MAX_WORDS = 2 ** ADDR_W
) (
   input  logic               clk,
   input  logic               reset,
   imem_loader_if.slave       bs,
   output logic               imem_we,
   output logic [31:0]        imem_wpc,
   output logic [31:0]        imem_wdata,
   output logic               cpu_reset,
   output logic               cpu_start,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [1:0]         err_code
);

   localparam logic [31:0] MAX_W = 32'(MAX_WORDS);

   loader_state_t     state_q, state_d;
   logic [7:0]        len_lo_q, len_lo_d;
   logic [ADDR_W:0]   n_q, n_d;
   logic [ADDR_W:0]   word_idx_q, word_idx_d;
   logic [1:0]        byte_idx_q, byte_idx_d;
   logic [23:0]       shift_q, shift_d;
   logic [7:0]        csum_q, csum_d;
   logic              ready_q, ready_d;
   logic              we_q, we_d;
   logic [31:0]       wpc_q, wpc_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   err_code_t         code_q, code_d;

   logic              accept;
   logic [15:0]       n_full;
   logic              len_bad;
   logic [ADDR_W:0]   word_nxt;

   assign accept   = bs.byte_valid && ready_q;
   assign n_full   = {bs.byte_data, len_lo_q};
   assign len_bad  = (n_full == 16'd0) || (32'(n_full) > MAX_W);
   // Counter is one bit wider than the address so N = 2^ADDR_W terminates cleanly.
   assign word_nxt = word_idx_q + {{ADDR_W{1'b0}}, 1'b1};

   always_comb begin
      state_d    = state_q;
      len_lo_d   = len_lo_q;
      n_d        = n_q;
      word_idx_d = word_idx_q;
      byte_idx_d = byte_idx_q;
      shift_d    = shift_q;
      csum_d     = csum_q;
      ready_d    = 1'b1;
      we_d       = 1'b0;
      wpc_d      = wpc_q;
      wdata_d    = wdata_q;
      done_d     = done_q;
      err_d      = err_q;
      code_d     = code_q;
      if (accept) begin
         unique case (state_q)
            ST_IDLE: if (bs.byte_data == SYNC_BYTE) state_d = ST_LEN0;
            ST_LEN0: begin
               len_lo_d = bs.byte_data;
               state_d  = ST_LEN1;
            end
            ST_LEN1: begin
               if (len_bad) begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
                  code_d  = ERR_LEN;
                  done_d  = 1'b0;
               end else begin
                  state_d    = ST_DATA;
                  n_d        = (ADDR_W+1)'(n_full);
                  word_idx_d = '0;
                  byte_idx_d = '0;
                  csum_d     = '0;
               end
            end
            ST_DATA: begin
               // Bytes arrive LSB first, so the newest byte enters at the top.
               shift_d    = {bs.byte_data, shift_q[23:8]};
               csum_d     = csum_q ^ bs.byte_data;
               byte_idx_d = byte_idx_q + 2'd1;
               if (byte_idx_q == 2'd3) begin
                  we_d       = 1'b1;
                  wpc_d      = 32'({word_idx_q[ADDR_W-1:0], 2'b00});
                  wdata_d    = {bs.byte_data, shift_q};
                  word_idx_d = word_nxt;
                  if (word_nxt == n_q) state_d = ST_CSUM;
               end
            end
            ST_CSUM: begin
               if (bs.byte_data == csum_q) begin
                  state_d = ST_RUN;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_ERR;
                  err_d   = 1'b1;
                  code_d  = ERR_CSUM;
                  done_d  = 1'b0;
               end
            end
            ST_RUN: if (bs.byte_data == SYNC_BYTE) begin
               state_d = ST_LEN0;
               done_d  = 1'b0;
            end
            ST_ERR: if (bs.byte_data == SYNC_BYTE) begin
               state_d = ST_LEN0;
               err_d   = 1'b0;
               code_d  = ERR_NONE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         len_lo_q   <= '0;
         n_q        <= '0;
         word_idx_q <= '0;
         byte_idx_q <= '0;
         shift_q    <= '0;
         csum_q     <= '0;
         ready_q    <= 1'b0;
         we_q       <= 1'b0;
         wpc_q      <= '0;
         wdata_q    <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         code_q     <= ERR_NONE;
      end else begin
         state_q    <= state_d;
         len_lo_q   <= len_lo_d;
         n_q        <= n_d;
         word_idx_q <= word_idx_d;
         byte_idx_q <= byte_idx_d;
         shift_q    <= shift_d;
         csum_q     <= csum_d;
         ready_q    <= ready_d;
         we_q       <= we_d;
         wpc_q      <= wpc_d;
         wdata_q    <= wdata_d;
         done_q     <= done_d;
         err_q      <= err_d;
         code_q     <= code_d;
      end
   end

   assign bs.byte_ready = ready_q;
   assign imem_we       = we_q;
   assign imem_wpc      = wpc_q;
   assign imem_wdata    = wdata_q;
   assign cpu_reset     = (state_q != ST_RUN);
   assign cpu_start     = (state_q == ST_RUN);
   assign busy          = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                          (state_q == ST_DATA) || (state_q == ST_CSUM);
   assign done          = done_q;
   assign err           = err_q;
   assign err_code      = code_q;

endmodule
